// File: rtl/contador_registro_4bits_pkg.sv
// Shared widths and types for the loadable counter/register block.
// Optional terminal-count output is selected with CONTADOR_TC_EN.
package contador_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef logic [CNT_W-1:0] cnt_t;

endpackage : contador_pkg

// File: rtl/contador_registro_4bits_if.sv
// Control/data bundle for contador_registro_4bits; the master drives
// the controls and load data, the slave (the counter) returns Y and, with CONTADOR_TC_EN, TC.
interface contador_registro_4bits_if
  import contador_pkg::*;
#(
  parameter int WIDTH = CNT_W
);

  logic             EN;
  logic             LD;
  logic             OE;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Y;
`ifdef CONTADOR_TC_EN
  logic             TC;

  modport master (
    output EN,
    output LD,
    output OE,
    output D,
    input  Y,
    input  TC
  );

  modport slave (
    input  EN,
    input  LD,
    input  OE,
    input  D,
    output Y,
    output TC
  );
`else
  modport master (
    output EN,
    output LD,
    output OE,
    output D,
    input  Y
  );

  modport slave (
    input  EN,
    input  LD,
    input  OE,
    input  D,
    output Y
  );
`endif

endinterface : contador_registro_4bits_if

// File: rtl/contador_registro_4bits_oe_gate.sv
// Output-enable mask: passes the counter value when oe is high, zeros otherwise.
module contador_oe_gate #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             oe,
  output logic [WIDTH-1:0] y
);

  assign y = cnt & {WIDTH{oe}};

endmodule : contador_oe_gate

// File: rtl/contador_registro_4bits.sv
// Loadable up-counter/register with count enable and output enable.
// Define CONTADOR_TC_EN to add the combinational terminal-count output TC.
module contador_registro_4bits
  import contador_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  contador_registro_4bits_if.slave bus
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;

  // Load has priority over counting; the increment wraps naturally at 2^WIDTH.
  always_comb begin
    cnt_nxt = cnt;
    if (bus.LD) begin
      cnt_nxt = bus.D;
    end else if (bus.EN) begin
      cnt_nxt = cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  contador_oe_gate #(
    .WIDTH (WIDTH)
  ) u_oe_gate (
    .cnt (cnt),
    .oe  (bus.OE),
    .y   (bus.Y)
  );

`ifdef CONTADOR_TC_EN
  // Flags the cycle whose edge will wrap the counter back to zero; OE plays no part.
  assign bus.TC = bus.EN & ~bus.LD & (cnt == {WIDTH{1'b1}});
`endif

endmodule : contador_registro_4bits

// File: tb/tb_contador_registro_4bits.sv
// Directed bench for contador_registro_4bits: an arithmetic model checked every
// cycle plus hand-computed expectations for each scenario.
module tb_contador_registro_4bits;

  logic clk;
  logic rst_n;

  int checks;
  int errors;
  bit chk_en;
  int model;

  contador_registro_4bits_if #(.WIDTH(4)) bus ();

  contador_registro_4bits #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: counter value as a plain integer modulo 16.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model <= 0;
    else if (bus.LD) model <= int'(bus.D);
    else if (bus.EN) model <= (model + 1) % 16;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_y", int'(bus.Y), bus.OE ? model : 0);
`ifdef CONTADOR_TC_EN
      chk("model_tc", int'(bus.TC),
          (bus.EN && !bus.LD && model == 15) ? 1 : 0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [3:0] exp2 [4];
  logic [3:0] exp4 [3];

  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    model  = 0;
    exp2 = '{4'hB, 4'hC, 4'hD, 4'hE};
    exp4 = '{4'hD, 4'hE, 4'hF};

    // 1: reset dominates active controls
    rst_n = 1'b1;
    bus.EN = 1'b1; bus.LD = 1'b1; bus.OE = 1'b1; bus.D = 4'hA;
    #1 rst_n = 1'b0;
    #1;
    chk("t1_reset_async", int'(bus.Y), 0);
    chk_en = 1'b1;
    tick();
    tick();
    chk("t1_reset_held", int'(bus.Y), 0);
    rst_n = 1'b1;
    tick();
    chk("t1_first_edge", int'(bus.Y), 'hA);

    // 2: load then count
    bus.LD = 1'b1; bus.EN = 1'b1; bus.D = 4'b1010;
    tick();
    chk("t2_load", int'(bus.Y), 'hA);
    bus.LD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_count", int'(bus.Y), int'(exp2[i]));
    end

    // 3: OE masks output but counting continues
    bus.OE = 1'b0;
    #1 chk("t3_oe_comb", int'(bus.Y), 0);
    tick();
    chk("t3_oe_off", int'(bus.Y), 0);
    bus.OE = 1'b1;
    #1 chk("t3_oe_back", int'(bus.Y), 'hF);

    // 4: hold, then load and count
    bus.EN = 1'b0;
    tick();
    chk("t4_hold1", int'(bus.Y), 'hF);
    tick();
    chk("t4_hold2", int'(bus.Y), 'hF);
    bus.EN = 1'b1; bus.LD = 1'b1; bus.D = 4'b1100;
    tick();
    chk("t4_load", int'(bus.Y), 'hC);
    bus.LD = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_count", int'(bus.Y), int'(exp4[i]));
    end

    // 5: wrap and terminal count
    bus.LD = 1'b1; bus.D = 4'hE;
    tick();
    chk("t5_load_e", int'(bus.Y), 'hE);
    bus.LD = 1'b0;
`ifdef CONTADOR_TC_EN
    #1 chk("t5_tc_at_e", int'(bus.TC), 0);
`endif
    tick();
    chk("t5_at_f", int'(bus.Y), 'hF);
`ifdef CONTADOR_TC_EN
    chk("t5_tc_at_f", int'(bus.TC), 1);
    bus.EN = 1'b0;
    #1 chk("t5_tc_en0", int'(bus.TC), 0);
    bus.LD = 1'b1; bus.EN = 1'b1; bus.D = 4'hF;
    #1 chk("t5_tc_ld1", int'(bus.TC), 0);
    bus.LD = 1'b0; bus.OE = 1'b0;
    #1 chk("t5_tc_oe0", int'(bus.TC), 1);
    bus.OE = 1'b1;
`endif
    tick();
    chk("t5_wrap", int'(bus.Y), 0);
`ifdef CONTADOR_TC_EN
    chk("t5_tc_after", int'(bus.TC), 0);
`endif

    // 6: load ignores EN, async reset mid-cycle, release with load pending
    bus.LD = 1'b1; bus.EN = 1'b0; bus.D = 4'h3;
    tick();
    chk("t6_load_no_en", int'(bus.Y), 'h3);
    #1 rst_n = 1'b0;
    #1 chk("t6_async_rst", int'(bus.Y), 0);
    bus.D = 4'h5; bus.EN = 1'b1;
    tick();
    chk("t6_rst_held", int'(bus.Y), 0);
    rst_n = 1'b1;
    tick();
    chk("t6_release_load", int'(bus.Y), 'h5);
    bus.LD = 1'b0;
    tick();
    chk("t6_count_on", int'(bus.Y), 'h6);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_contador_registro_4bits
